// File: rtl/base_hps_button_pio.sv
// Avalon-MM input PIO for HPS buttons/switches.
// Each input bit passes through a 2-FF synchronizer and a per-bit debounce
// counter. Edges of the debounced level are latched in EDGE, and a level IRQ
// is raised for any captured edge whose MASK bit is set. Software clears
// EDGE bits by writing 1s to address 3.
module base_hps_button_pio #(
    parameter int unsigned            WIDTH           = 4,
    parameter int unsigned            DEBOUNCE_CYCLES = 50000,
    parameter int unsigned            EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0]       RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned      CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;

    // Upper write-data bits beyond WIDTH are don't-care for every register.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Per-bit debounce: a new level is accepted only after it has been
    // seen on the synchronized input for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge selection on the debounced level; deb_prev_q resets to the same
    // value as deb_q so reset itself never looks like an edge.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_evt = deb_q & ~deb_prev_q;
            1:       edge_evt = ~deb_q & deb_prev_q;
            default: edge_evt = deb_q ^ deb_prev_q;
        endcase
    end

    // Register-file write decode; a new edge wins over a same-cycle clear.
    always_comb begin
        edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~edge_clr) | edge_evt;
        mask_d   = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    end

    // All state: synchronizer, debounce, edge history, MASK and EDGE.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= RESET_VALUE;
            sync2_q    <= RESET_VALUE;
            deb_q      <= RESET_VALUE;
            deb_prev_q <= RESET_VALUE;
            mask_q     <= '0;
            edge_q     <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-wait-state read mux; reads have no side effects.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = deb_q;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule
